zphoton_dump_scheduler: RTL and testbench
=========================================

// Module: zphoton_dump_scheduler
// PURPOSE
// Sequences the UART data-dump block: counts photon pulses over a selectable time window,
// snapshots each window total into a small FIFO and hands samples one at a time to the dump
// block via its enable/update/done handshake. FIFO decouples short windows (2 ms) from packet
// transmit time; lost samples are counted. Sits between the photon pulse front-end and the dump block.
// PARAMETERS
// CLK_HZ      50_000_000  iClk frequency; window lengths derived as CLK_HZ/500, /100, /10, /2
// FIFO_AW     2           FIFO address width; depth = 2**FIFO_AW (default 4 entries)
// PORTS
// iClk            in   1   system clock, all logic on rising edge
// iRst_N          in   1   asynchronous active-low reset
// iEn             in   1   block enable; low = flush and idle
// iPulse          in   1   photon pulse, synchronous, one count per high cycle
// iTime_Interval  in   8   window code: 6=2ms 7=10ms 8=100ms 9=500ms, other=2ms
// iDump_Done      in   1   dump block packet-complete pulse (1 cycle)
// oDump_En        out  1   enable to dump block
// oNewDataUpdate  out  1   1-cycle load strobe to dump block
// oNewData        out  16  window photon count presented with oNewDataUpdate
// oOverflow_Cnt   out  8   samples dropped on FIFO full, saturates at 255
// oBusy           out  1   high when FIFO non-empty or dispatcher not IDLE
// BEHAVIOUR
// - Reset: all outputs 0; window counter 0, photon count 0, FIFO empty, FSM IDLE.
// - Window: iTime_Interval decoded and registered at each window start; a change mid-window
//   takes effect at the next boundary. Terminal count = window_clks-1; counter wraps to 0.
// - Count: 16-bit, saturates at 16'hFFFF. On terminal cycle the pushed value includes iPulse
//   of that cycle; next window count restarts at 0 (pulse not double-counted).
// - Push on terminal cycle. FIFO full and no pop that cycle -> sample dropped,
//   oOverflow_Cnt+1 (sat 255). Simultaneous push+pop on full FIFO -> push accepted, no drop.
// - Dispatcher FSM:
//   IDLE : FIFO non-empty -> pop head, go LOAD.
//   LOAD : oDump_En=1, oNewDataUpdate=1, oNewData=popped value (1 cycle) -> RUN.
//   RUN  : oDump_En=1 until iDump_Done=1 -> DRAIN.
//   DRAIN: oDump_En=1 for exactly 1 cycle (lets dump block clear its done and return to start)
//          -> IDLE with oDump_En=0.
// - Latency: terminal cycle push -> earliest oNewDataUpdate 2 cycles later (IDLE pop, LOAD).
// - oNewData holds last loaded value between loads; oNewDataUpdate low outside LOAD.
// - iDump_Done ignored in IDLE/LOAD/DRAIN.
// - iEn low: FSM -> IDLE, oDump_En=0, FIFO flushed, window counter and count cleared;
//   oOverflow_Cnt retained. Counting restarts from window start on iEn rising.
// - Reset mid-packet: immediate async clear of all state; dump block resets on same reset.
// TESTING (sim with CLK_HZ=1_000_000: 2ms=2000 clks, 10ms=10000 clks)
// 1 code 6, 5 pulses in window, iDump_Done 300 clks after LOAD -> oNewData=5, one oNewDataUpdate,
//   oDump_En high LOAD..DRAIN, low after.
// 2 iPulse held high 70000 clks with code 8 (100000 clks) -> oNewData=16'hFFFF (saturated).
// 3 iDump_Done never returned, code 6 for 6 windows -> FIFO fills 4 (1 in RUN + 4 queued),
//   oOverflow_Cnt=1; release done -> 4 further loads in push order.
// 4 pulse on terminal cycle and first cycle of next window -> first sample includes it, second
//   sample counts 1 from that pulse only.
// 5 switch code 6->7 mid-window -> current window ends at 2000 clks, next at +10000 clks;
//   code 3 -> 2000 clks.
// 6 drop iEn during RUN -> oDump_En=0 next cycle, oBusy=0, FIFO empty; assert iRst_N low mid-LOAD
//   -> all outputs 0 immediately.

Source files
------------

// File: rtl/zphoton_dump_scheduler.sv
// zphoton_dump_scheduler: counts photon pulses per selectable window, queues window totals
// in a small FIFO and dispatches them one at a time to the UART dump block.
module zphoton_dump_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int FIFO_AW = 2
) (
    input  logic        iClk,
    input  logic        iRst_N,
    input  logic        iEn,
    input  logic        iPulse,
    input  logic [7:0]  iTime_Interval,
    input  logic        iDump_Done,
    output logic        oDump_En,
    output logic        oNewDataUpdate,
    output logic [15:0] oNewData,
    output logic [7:0]  oOverflow_Cnt,
    output logic        oBusy
);
    localparam int          DEPTH = 2 ** FIFO_AW;
    localparam logic [31:0] T_2MS   = 32'(CLK_HZ / 500 - 1);
    localparam logic [31:0] T_10MS  = 32'(CLK_HZ / 100 - 1);
    localparam logic [31:0] T_100MS = 32'(CLK_HZ / 10 - 1);
    localparam logic [31:0] T_500MS = 32'(CLK_HZ / 2 - 1);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  LOAD  = 2'd1;
    localparam logic [1:0]  RUN   = 2'd2;
    localparam logic [1:0]  DRAIN = 2'd3;

    logic [31:0]        r_win_cnt, r_term;
    logic [15:0]        r_cnt, r_data;
    logic [7:0]         r_ovf;
    logic [1:0]         r_state;
    logic [15:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [FIFO_AW:0]   r_fcnt;

    logic [31:0] w_dec, w_term;
    logic [15:0] w_sum;
    logic [1:0]  w_next;
    logic        w_tc, w_empty, w_full, w_pop, w_push, w_drop;

    always_comb begin
        w_dec = (iTime_Interval == 8'd7) ? T_10MS :
                (iTime_Interval == 8'd8) ? T_100MS :
                (iTime_Interval == 8'd9) ? T_500MS : T_2MS;
        // the window length is sampled live on its first cycle, then held until the boundary
        w_term  = (r_win_cnt == 32'd0) ? w_dec : r_term;
        w_tc    = iEn && (r_win_cnt == w_term);
        w_sum   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + {15'd0, iPulse};
        w_empty = (r_fcnt == '0);
        w_full  = (r_fcnt == (FIFO_AW+1)'(DEPTH));
        w_pop   = iEn && (r_state == IDLE) && !w_empty;
        w_push  = w_tc && (!w_full || w_pop);
        w_drop  = w_tc && w_full && !w_pop;
        w_next  = (r_state == IDLE) ? (w_empty ? IDLE : LOAD) :
                  (r_state == LOAD) ? RUN :
                  (r_state == RUN)  ? (iDump_Done ? DRAIN : RUN) : IDLE;
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_win_cnt <= '0;
            r_term    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_ovf     <= '0;
            r_state   <= IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_fcnt    <= '0;
        end else if (!iEn) begin
            r_win_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_fcnt    <= '0;
        end else begin
            r_term    <= w_term;
            r_win_cnt <= w_tc ? 32'd0 : r_win_cnt + 32'd1;
            r_cnt     <= w_tc ? 16'd0 : w_sum;
            r_state   <= w_next;
            r_data    <= w_pop ? r_mem[r_rp] : r_data;
            r_ovf     <= (w_drop && r_ovf != 8'hFF) ? r_ovf + 8'd1 : r_ovf;
            r_wp      <= w_push ? r_wp + FIFO_AW'(1) : r_wp;
            r_rp      <= w_pop ? r_rp + FIFO_AW'(1) : r_rp;
            r_fcnt    <= r_fcnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push) r_mem[r_wp] <= w_sum;
    end

    assign oDump_En       = (r_state != IDLE);
    assign oNewDataUpdate = (r_state == LOAD);
    assign oNewData       = r_data;
    assign oOverflow_Cnt  = r_ovf;
    assign oBusy          = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_zphoton_dump_scheduler.sv
// tb_zphoton_dump_scheduler: randomized run against a queue-based reference of windows,
// FIFO occupancy and packet handshake phases.
module tb_zphoton_dump_scheduler;
    localparam int CLK = 655_400;

    logic        iClk = 0, iRst_N = 0, iEn = 0, iPulse = 0, iDump_Done = 0;
    logic [7:0]  iTime_Interval = 8'd6;
    logic        oDump_En, oNewDataUpdate, oBusy;
    logic [15:0] oNewData;
    logic [7:0]  oOverflow_Cnt;

    int n_cmp = 0, n_bad = 0;
    int m_pos, m_len, m_cnt, m_ovf, m_phase, m_held;
    int q[$];
    int cur_code = 6;
    int codes[6] = '{6, 0, 3, 250, 7, 6};

    zphoton_dump_scheduler #(.CLK_HZ(CLK), .FIFO_AW(2)) dut (
        .iClk(iClk), .iRst_N(iRst_N), .iEn(iEn), .iPulse(iPulse),
        .iTime_Interval(iTime_Interval), .iDump_Done(iDump_Done),
        .oDump_En(oDump_En), .oNewDataUpdate(oNewDataUpdate), .oNewData(oNewData),
        .oOverflow_Cnt(oOverflow_Cnt), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int win_len(input int code);
        return (code == 7) ? CLK / 100 : (code == 8) ? CLK / 10 : (code == 9) ? CLK / 2 : CLK / 500;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_len = 0; m_cnt = 0; m_ovf = 0; m_phase = 0; m_held = 0;
        q.delete();
    endtask

    // phases: 0 idle, 1 load strobe, 2 waiting for done, 3 one-cycle drain
    task automatic model_step(input bit en, input bit pulse, input int code, input bit done);
        int sum;
        bit tc;
        if (!en) begin
            m_pos = 0; m_cnt = 0; m_phase = 0;
            q.delete();
            return;
        end
        if (m_pos == 0) m_len = win_len(code);
        sum = m_cnt + int'(pulse);
        if (sum > 65535) sum = 65535;
        tc = (m_pos == m_len - 1);
        if (m_phase == 0) begin
            if (q.size() > 0) begin m_held = q.pop_front(); m_phase = 1; end
        end else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) begin
            if (done) m_phase = 3;
        end else m_phase = 0;
        if (tc) begin
            if (q.size() < 4) q.push_back(sum);
            else if (m_ovf < 255) m_ovf++;
        end
        m_cnt = tc ? 0 : sum;
        m_pos = tc ? 0 : m_pos + 1;
    endtask

    task automatic compare();
        chk("dump_en", int'(oDump_En), int'(m_phase != 0));
        chk("update", int'(oNewDataUpdate), int'(m_phase == 1));
        chk("data", int'(oNewData), m_held);
        chk("ovf", int'(oOverflow_Cnt), m_ovf);
        chk("busy", int'(oBusy), int'(m_phase != 0 || q.size() > 0));
    endtask

    task automatic step(input bit en, input bit pulse, input int code, input bit done);
        iEn = en; iPulse = pulse; iTime_Interval = 8'(code); iDump_Done = done;
        @(posedge iClk);
        model_step(en, pulse, code, done);
        @(negedge iClk);
        compare();
    endtask

    // code_sel: 0 fixed code 6, 1 random code walk, 2 fixed code 8
    task automatic run(input int n, input int code_sel, input int done_div, input int en_div, input int pulse_pct);
        for (int i = 0; i < n; i++) begin
            bit en, pu, dn;
            if (code_sel == 1 && $urandom_range(0, 2499) == 0) cur_code = codes[$urandom_range(0, 5)];
            pu = ($urandom_range(0, 99) < pulse_pct);
            dn = (done_div > 0) && ($urandom_range(0, done_div - 1) == 0);
            en = !((en_div > 0) && ($urandom_range(0, en_div - 1) == 0));
            step(en, pu, (code_sel == 0) ? 6 : (code_sel == 2) ? 8 : cur_code, dn);
        end
    endtask

    initial begin
        int ovf_before;
        bit seen;
        model_reset();
        repeat (3) @(negedge iClk);
        compare();
        iRst_N = 1;
        run(4000, 1, 150, 0, 25);
        step(0, 0, 6, 0);
        ovf_before = m_ovf;
        run(7900, 0, 0, 0, 30);
        chk("ovf_after_stall", int'(oOverflow_Cnt), (ovf_before < 255) ? ovf_before + 1 : 255);
        chk("busy_stall", int'(oBusy), 1);
        run(3000, 0, 20, 0, 25);
        run(3500, 1, 100, 1500, 25);
        step(0, 0, 8, 0);
        run(65538, 2, 0, 0, 100);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 1, 8, 0);
            if (oNewDataUpdate) begin
                seen = 1;
                chk("saturated", int'(oNewData), 65535);
            end
        end
        if (!seen) chk("sat_timeout", 0, 1);
        step(1, 0, 6, 1);
        step(0, 0, 6, 0);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            step(1, $urandom_range(0, 3) == 0, 6, 0);
            seen = oNewDataUpdate;
        end
        if (!seen) chk("load_timeout", 0, 1);
        iRst_N = 0;
        #1;
        chk("rst_en", int'(oDump_En), 0);
        chk("rst_update", int'(oNewDataUpdate), 0);
        chk("rst_data", int'(oNewData), 0);
        chk("rst_ovf", int'(oOverflow_Cnt), 0);
        chk("rst_busy", int'(oBusy), 0);
        model_reset();
        @(posedge iClk);
        @(negedge iClk);
        iRst_N = 1;
        run(2800, 0, 50, 0, 25);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
